// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FMA operand dispatcher:
//   FP               - operand width in bits (single-precision layout)
//   DEPTH_DEFAULT    - default depth of the operand-pair FIFO
//   float_sp         - single-precision field view of an operand
//   dispatch_state_e - dispatcher FSM state encoding (2 bits)
//   pair_a/pair_b    - helpers that split a packed {A,B} FIFO word
// -----------------------------------------------------------------------------
package fpu_pkg;

  localparam int FP            = 32;
  localparam int DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float_sp;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } dispatch_state_e;

  // A occupies the upper half of the FIFO word, B the lower half.
  function automatic logic [FP-1:0] pair_a(input logic [2*FP-1:0] pair);
    return pair[2*FP-1:FP];
  endfunction

  function automatic logic [FP-1:0] pair_b(input logic [2*FP-1:0] pair);
    return pair[FP-1:0];
  endfunction

endpackage

// File: rtl/fpu_fma_dispatch_if.sv
// -----------------------------------------------------------------------------
// fpu_fma_dispatch_if
// Bundles every non-clock/reset signal of the dispatcher.
//   Producer side : op_valid_in, op_ready_out, op_a_in, op_b_in
//   FMA channel 0 : float_0_out, float_0_req_out, float_0_busy_in
//   FMA channel 1 : float_1_out, float_1_req_out, float_1_busy_in
//   FMA status    : fma_busy_in, ready_answer_in, overflow_in, underflow_in
//   Observability : issued_count_out, exception_out, state_out
// Modports:
//   slave  - the dispatcher (consumes operands, drives the FMA channels)
//   master - the environment (producer + FMA)
// -----------------------------------------------------------------------------
interface fpu_fma_dispatch_if #(
  parameter int FP = fpu_pkg::FP
);
  import fpu_pkg::*;

  logic            op_valid_in;
  logic            op_ready_out;
  logic [FP-1:0]   op_a_in;
  logic [FP-1:0]   op_b_in;

  logic [FP-1:0]   float_0_out;
  logic            float_0_req_out;
  logic            float_0_busy_in;
  logic [FP-1:0]   float_1_out;
  logic            float_1_req_out;
  logic            float_1_busy_in;

  logic            fma_busy_in;
  logic            ready_answer_in;
  logic            overflow_in;
  logic            underflow_in;

  logic [7:0]      issued_count_out;
  logic            exception_out;
  dispatch_state_e state_out;

  modport slave (
    input  op_valid_in, op_a_in, op_b_in,
    input  float_0_busy_in, float_1_busy_in,
    input  fma_busy_in, ready_answer_in, overflow_in, underflow_in,
    output op_ready_out,
    output float_0_out, float_0_req_out, float_1_out, float_1_req_out,
    output issued_count_out, exception_out, state_out
  );

  modport master (
    output op_valid_in, op_a_in, op_b_in,
    output float_0_busy_in, float_1_busy_in,
    output fma_busy_in, ready_answer_in, overflow_in, underflow_in,
    input  op_ready_out,
    input  float_0_out, float_0_req_out, float_1_out, float_1_req_out,
    input  issued_count_out, exception_out, state_out
  );

endinterface

// File: rtl/fpu_pair_fifo.sv
// -----------------------------------------------------------------------------
// fpu_pair_fifo
// Synchronous FIFO holding packed {A,B} operand pairs.
//   clk, rst  - clock, asynchronous active-high reset (empties the FIFO)
//   push_i    - write data_i (ignored when full)
//   pop_i     - drop the head entry (ignored when empty)
//   data_i    - W-bit entry to write
//   full_o    - DEPTH entries held
//   empty_o   - no entries held
//   head_o    - oldest entry (only meaningful when !empty_o)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fpu_pair_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (pop_ok)  rd_d = rd_q + AW'(1);
    // Simultaneous push and pop leaves the occupancy unchanged.
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage is not reset: reset only clears the pointers, which discards
  // whatever the array still holds.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fpu_fma_dispatch.sv
// -----------------------------------------------------------------------------
// fpu_fma_dispatch
// Buffers {A,B} operand pairs from a valid/ready producer and hands them to an
// FMA over two independent req/busy channels (channel 0 = A, channel 1 = B),
// then waits for the FMA's ready_answer pulse before dispatching the next pair.
//   clk - clock, all state changes on its rising edge
//   rst - asynchronous active-high reset
//   bus - fpu_fma_dispatch_if.slave: producer handshake, FMA channels,
//         FMA status, and the issued-count / sticky-exception / state outputs
// FSM: IDLE -> SEND (FIFO non-empty and FMA not busy)
//      SEND -> WAIT (both channels transferred; head popped on that edge)
//      WAIT -> IDLE (ready_answer_in; count and exception updated)
// -----------------------------------------------------------------------------
module fpu_fma_dispatch #(
  parameter int FP    = fpu_pkg::FP,
  parameter int DEPTH = fpu_pkg::DEPTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  fpu_fma_dispatch_if.slave   bus
);
  import fpu_pkg::*;

  localparam int PW = 2 * FP;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [PW-1:0] fifo_head;

  dispatch_state_e state_q;
  logic            req0_q, req1_q;
  logic            sent0_q, sent1_q;
  logic [FP-1:0]   float0_q, float1_q;
  logic [7:0]      cnt_q, cnt_d;
  logic            exc_q, exc_d;

  logic xfer0, xfer1, done0, done1, start;

  // No bypass: a pair offered while full simply waits for a pop.
  assign fifo_push        = bus.op_valid_in && !fifo_full;
  assign bus.op_ready_out = !fifo_full;

  fpu_pair_fifo #(
    .W     (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  ({bus.op_a_in, bus.op_b_in}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  // A channel is finished once it has transferred earlier (sent flag) or is
  // transferring on this edge; SEND ends when both are finished, which also
  // covers both channels completing on the same edge.
  assign xfer0    = req0_q && !bus.float_0_busy_in;
  assign xfer1    = req1_q && !bus.float_1_busy_in;
  assign done0    = sent0_q || xfer0;
  assign done1    = sent1_q || xfer1;
  assign start    = (state_q == IDLE) && !fifo_empty && !bus.fma_busy_in;
  assign fifo_pop = (state_q == SEND) && done0 && done1;

  // Issued count wraps 255 -> 0; the exception flag is sticky until reset.
  always_comb begin
    cnt_d = cnt_q + 8'd1;
    exc_d = exc_q || bus.overflow_in || bus.underflow_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req0_q   <= 1'b0;
      req1_q   <= 1'b0;
      sent0_q  <= 1'b0;
      sent1_q  <= 1'b0;
      float0_q <= '0;
      float1_q <= '0;
      cnt_q    <= '0;
      exc_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= SEND;
            req0_q   <= 1'b1;
            req1_q   <= 1'b1;
            sent0_q  <= 1'b0;
            sent1_q  <= 1'b0;
            // Operands are latched here so they stay stable for all of SEND.
            float0_q <= pair_a(fifo_head);
            float1_q <= pair_b(fifo_head);
          end
        end
        SEND: begin
          if (done0 && done1) begin
            state_q <= WAIT;
            req0_q  <= 1'b0;
            req1_q  <= 1'b0;
            sent0_q <= 1'b0;
            sent1_q <= 1'b0;
          end else begin
            if (xfer0) begin
              req0_q  <= 1'b0;
              sent0_q <= 1'b1;
            end
            if (xfer1) begin
              req1_q  <= 1'b0;
              sent1_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (bus.ready_answer_in) begin
            state_q <= IDLE;
            cnt_q   <= cnt_d;
            exc_q   <= exc_d;
          end
        end
        default: begin
          state_q <= IDLE;
          req0_q  <= 1'b0;
          req1_q  <= 1'b0;
          sent0_q <= 1'b0;
          sent1_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.float_0_out      = float0_q;
  assign bus.float_1_out      = float1_q;
  assign bus.float_0_req_out  = req0_q;
  assign bus.float_1_req_out  = req1_q;
  assign bus.issued_count_out = cnt_q;
  assign bus.exception_out    = exc_q;
  assign bus.state_out        = state_q;

endmodule

// File: tb/tb_fpu_fma_dispatch.sv
// -----------------------------------------------------------------------------
// tb_fpu_fma_dispatch
// Directed bench for fpu_fma_dispatch: single pair, skewed channels, full FIFO
// ordering, sticky exception, count wrap and reset during SEND.
// -----------------------------------------------------------------------------
module tb_fpu_fma_dispatch;
  import fpu_pkg::*;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  fpu_fma_dispatch_if #(.FP(32)) bus ();

  fpu_fma_dispatch #(
    .FP    (32),
    .DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_c(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_s(input string tag, input dispatch_state_e obs, input dispatch_state_e exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%s expected=%s", tag, obs.name(), exp.name());
    end
  endtask

  // Bounded wait for a state; an expired bound shows up as a failed check.
  task automatic wait_state(input string tag, input dispatch_state_e st, input int max_cycles);
    int n;
    n = 0;
    while (bus.state_out != st && n < max_cycles) begin
      tick();
      n++;
    end
    chk_s(tag, bus.state_out, st);
  endtask

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b);
    bus.op_valid_in = 1'b1;
    bus.op_a_in     = a;
    bus.op_b_in     = b;
    tick();
    bus.op_valid_in = 1'b0;
  endtask

  // Waits for SEND, checks the presented operands, waits for WAIT, answers.
  task automatic issue_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic ov, input logic uf);
    wait_state({tag, "_send"}, SEND, 12);
    chk_w({tag, "_a"}, bus.float_0_out, a);
    chk_w({tag, "_b"}, bus.float_1_out, b);
    wait_state({tag, "_wait"}, WAIT, 12);
    bus.overflow_in     = ov;
    bus.underflow_in    = uf;
    bus.ready_answer_in = 1'b1;
    tick();
    bus.ready_answer_in = 1'b0;
    bus.overflow_in     = 1'b0;
    bus.underflow_in    = 1'b0;
  endtask

  logic [31:0] pa [5];
  logic [31:0] pb [5];

  initial begin
    pa[0] = 32'h3F800000; pb[0] = 32'h40000000;
    pa[1] = 32'h40400000; pb[1] = 32'h40800000;
    pa[2] = 32'hBF800000; pb[2] = 32'h3F000000;
    pa[3] = 32'h7F7FFFFF; pb[3] = 32'h00800000;
    pa[4] = 32'h42C80000; pb[4] = 32'hC2C80000;

    rst                 = 1'b1;
    bus.op_valid_in     = 1'b0;
    bus.op_a_in         = '0;
    bus.op_b_in         = '0;
    bus.float_0_busy_in = 1'b0;
    bus.float_1_busy_in = 1'b0;
    bus.fma_busy_in     = 1'b0;
    bus.ready_answer_in = 1'b0;
    bus.overflow_in     = 1'b0;
    bus.underflow_in    = 1'b0;

    // Reset state
    #12;
    chk_s("rst_state", bus.state_out, IDLE);
    chk_b("rst_req0", bus.float_0_req_out, 1'b0);
    chk_b("rst_req1", bus.float_1_req_out, 1'b0);
    chk_w("rst_f0", bus.float_0_out, 32'h0);
    chk_w("rst_f1", bus.float_1_out, 32'h0);
    chk_c("rst_cnt", bus.issued_count_out, 8'd0);
    chk_b("rst_exc", bus.exception_out, 1'b0);
    chk_b("rst_ready", bus.op_ready_out, 1'b1);
    rst = 1'b0;
    tick();

    // Single pair: push at edge T, SEND with both reqs at T+1
    push_pair(32'h3F800000, 32'h40000000);
    chk_s("t1_idle_after_push", bus.state_out, IDLE);
    tick();
    chk_s("t1_send", bus.state_out, SEND);
    chk_b("t1_req0", bus.float_0_req_out, 1'b1);
    chk_b("t1_req1", bus.float_1_req_out, 1'b1);
    chk_w("t1_f0", bus.float_0_out, 32'h3F800000);
    chk_w("t1_f1", bus.float_1_out, 32'h40000000);
    tick();
    chk_s("t1_wait", bus.state_out, WAIT);
    chk_b("t1_wait_req0", bus.float_0_req_out, 1'b0);
    chk_b("t1_wait_req1", bus.float_1_req_out, 1'b0);
    tick();
    chk_s("t1_still_wait", bus.state_out, WAIT);
    bus.ready_answer_in = 1'b1;
    tick();
    bus.ready_answer_in = 1'b0;
    chk_c("t1_cnt", bus.issued_count_out, 8'd1);
    chk_s("t1_idle", bus.state_out, IDLE);

    // ready_answer_in ignored outside WAIT
    bus.ready_answer_in = 1'b1;
    bus.overflow_in     = 1'b1;
    tick();
    bus.ready_answer_in = 1'b0;
    bus.overflow_in     = 1'b0;
    chk_c("ign_cnt", bus.issued_count_out, 8'd1);
    chk_b("ign_exc", bus.exception_out, 1'b0);

    // Skewed channels: channel 1 busy for 3 cycles
    bus.float_1_busy_in = 1'b1;
    push_pair(32'h40400000, 32'h40800000);
    tick();
    chk_s("t2_send", bus.state_out, SEND);
    chk_b("t2_c1_req0", bus.float_0_req_out, 1'b1);
    chk_b("t2_c1_req1", bus.float_1_req_out, 1'b1);
    tick();
    chk_b("t2_c2_req0", bus.float_0_req_out, 1'b0);
    chk_b("t2_c2_req1", bus.float_1_req_out, 1'b1);
    chk_s("t2_c2_state", bus.state_out, SEND);
    tick();
    chk_b("t2_c3_req1", bus.float_1_req_out, 1'b1);
    chk_w("t2_c3_f1", bus.float_1_out, 32'h40800000);
    tick();
    chk_b("t2_c4_req1", bus.float_1_req_out, 1'b1);
    chk_s("t2_c4_state", bus.state_out, SEND);
    chk_w("t2_c4_f0", bus.float_0_out, 32'h40400000);
    chk_w("t2_c4_f1", bus.float_1_out, 32'h40800000);
    bus.float_1_busy_in = 1'b0;
    tick();
    chk_s("t2_wait", bus.state_out, WAIT);
    chk_b("t2_req1_low", bus.float_1_req_out, 1'b0);
    bus.ready_answer_in = 1'b1;
    tick();
    bus.ready_answer_in = 1'b0;
    chk_c("t2_cnt", bus.issued_count_out, 8'd2);
    // FIFO must be empty again: nothing left to dispatch
    tick();
    tick();
    chk_s("t2_empty_idle", bus.state_out, IDLE);

    // Full FIFO with the FMA busy
    bus.fma_busy_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_b("t3_ready_before_push", bus.op_ready_out, 1'b1);
      push_pair(pa[i], pb[i]);
    end
    chk_b("t3_full", bus.op_ready_out, 1'b0);
    bus.op_valid_in = 1'b1;
    bus.op_a_in     = pa[4];
    bus.op_b_in     = pb[4];
    tick();
    tick();
    chk_b("t3_still_full", bus.op_ready_out, 1'b0);
    chk_s("t3_idle_busy", bus.state_out, IDLE);
    bus.fma_busy_in = 1'b0;
    tick();
    chk_s("t3_send0", bus.state_out, SEND);
    chk_w("t3_p0_a", bus.float_0_out, pa[0]);
    chk_w("t3_p0_b", bus.float_1_out, pb[0]);
    tick();
    chk_s("t3_wait0", bus.state_out, WAIT);
    chk_b("t3_ready_after_pop", bus.op_ready_out, 1'b1);
    tick();
    bus.op_valid_in = 1'b0;
    chk_b("t3_full_again", bus.op_ready_out, 1'b0);
    bus.ready_answer_in = 1'b1;
    tick();
    bus.ready_answer_in = 1'b0;
    for (int i = 1; i < 5; i++) begin
      issue_one("t3_order", pa[i], pb[i], 1'b0, 1'b0);
    end
    chk_c("t3_cnt", bus.issued_count_out, 8'd7);
    chk_b("t3_exc_clean", bus.exception_out, 1'b0);

    // Sticky exception
    push_pair(32'h7F7FFFFF, 32'h7F7FFFFF);
    issue_one("t4_ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, 1'b0);
    chk_b("t4_exc_set", bus.exception_out, 1'b1);
    push_pair(32'h3F800000, 32'h3F800000);
    issue_one("t4_clean", 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
    chk_b("t4_exc_sticky", bus.exception_out, 1'b1);
    chk_c("t4_cnt", bus.issued_count_out, 8'd9);

    // Reset clears count and exception, then 256 completions wrap to 0
    #2 rst = 1'b1;
    #1;
    chk_c("t5_rst_cnt", bus.issued_count_out, 8'd0);
    chk_b("t5_rst_exc", bus.exception_out, 1'b0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 255; i++) begin
      push_pair(32'(i), ~32'(i));
      issue_one("t5_loop", 32'(i), ~32'(i), 1'b0, 1'b0);
    end
    chk_c("t5_cnt255", bus.issued_count_out, 8'd255);
    push_pair(32'h12345678, 32'h9ABCDEF0);
    issue_one("t5_last", 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0);
    chk_c("t5_wrap", bus.issued_count_out, 8'd0);

    // Reset during SEND with two pairs queued
    push_pair(pa[1], pb[1]);
    bus.float_0_busy_in = 1'b1;
    bus.float_1_busy_in = 1'b1;
    push_pair(pa[2], pb[2]);
    wait_state("t6_send", SEND, 4);
    chk_b("t6_req0_hi", bus.float_0_req_out, 1'b1);
    chk_b("t6_req1_hi", bus.float_1_req_out, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_b("t6_req0_rst", bus.float_0_req_out, 1'b0);
    chk_b("t6_req1_rst", bus.float_1_req_out, 1'b0);
    chk_s("t6_state_rst", bus.state_out, IDLE);
    chk_b("t6_ready_rst", bus.op_ready_out, 1'b1);
    chk_w("t6_f0_rst", bus.float_0_out, 32'h0);
    chk_c("t6_cnt_rst", bus.issued_count_out, 8'd0);
    rst = 1'b0;
    bus.float_0_busy_in = 1'b0;
    bus.float_1_busy_in = 1'b0;
    tick();
    tick();
    tick();
    chk_s("t6_fifo_empty", bus.state_out, IDLE);
    chk_c("t6_no_incr", bus.issued_count_out, 8'd0);
    push_pair(pa[3], pb[3]);
    issue_one("t6_resume", pa[3], pb[3], 1'b0, 1'b1);
    chk_c("t6_cnt_after", bus.issued_count_out, 8'd1);
    chk_b("t6_uflow_exc", bus.exception_out, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_fma_dispatch.md
FPU_FMA_DISPATCH -- requirements
Module: fpu_fma_dispatch

Interface
REQ-001 SHALL have parameter FP, default 32: operand width in bits (float_sp layout).
REQ-002 SHALL have parameter DEPTH, default 4: operand-pair FIFO depth, a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port op_valid_in, input, 1 bit: the producer offers an operand pair.
REQ-006 SHALL have port op_ready_out, output, 1 bit: the dispatcher can accept a pair.
REQ-007 SHALL have port op_a_in, input, FP bits: multiplicand A, float_sp.
REQ-008 SHALL have port op_b_in, input, FP bits: multiplicand B, float_sp.
REQ-009 SHALL have port float_0_out, output, FP bits: operand A to the FMA.
REQ-010 SHALL have port float_0_req_out, output, 1 bit: channel 0 request.
REQ-011 SHALL have port float_0_busy_in, input, 1 bit: the FMA stalls channel 0.
REQ-012 SHALL have port float_1_out, output, FP bits: operand B to the FMA.
REQ-013 SHALL have port float_1_req_out, output, 1 bit: channel 1 request.
REQ-014 SHALL have port float_1_busy_in, input, 1 bit: the FMA stalls channel 1.
REQ-015 SHALL have port fma_busy_in, input, 1 bit: the FMA busy_out.
REQ-016 SHALL have port ready_answer_in, input, 1 bit: the FMA result-ready pulse.
REQ-017 SHALL have ports overflow_in and underflow_in, input, 1 bit each: FMA exception flags, sampled with ready_answer_in.
REQ-018 SHALL have port issued_count_out, output, 8 bits: completed operations.
REQ-019 SHALL have port exception_out, output, 1 bit: sticky overflow/underflow seen.
REQ-020 SHALL have port state_out, output, dispatch_state_e: current FSM state.

Function
REQ-021 SHALL buffer {A,B} pairs in a DEPTH-entry FIFO; push on op_valid_in && op_ready_out; op_ready_out = !full, combinational from occupancy, with no bypass when full.
REQ-022 SHALL implement the FSM states IDLE, SEND and WAIT.
REQ-023 IDLE SHALL move to SEND when the FIFO is non-empty and fma_busy_in=0; otherwise it stays in IDLE.
REQ-024 In SEND, float_N_req_out SHALL be high until channel N transfers (req && !busy at a clock edge); each channel is independent, with a per-channel sent flag.
REQ-025 float_0_out and float_1_out SHALL present the FIFO head and stay stable throughout SEND.
REQ-026 SEND SHALL pop the head and move to WAIT at the edge where the second channel completes, including when both channels complete in the same cycle.
REQ-027 In WAIT, both req outputs SHALL be low; on ready_answer_in the block SHALL increment issued_count_out, set exception_out if overflow_in or underflow_in is high, and return to IDLE.
REQ-028 ready_answer_in SHALL be ignored outside WAIT.
REQ-029 issued_count_out SHALL wrap from 255 to 0.
REQ-030 A push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-031 For a push at edge T into an empty FIFO while IDLE and fma_busy_in=0, the FSM SHALL be in SEND from edge T+1, with both reqs high from edge T+1.
REQ-032 exception_out SHALL clear only on reset.

Reset
REQ-033 rst SHALL immediately force: state IDLE, FIFO empty (contents discarded), sent flags 0, both reqs 0, float_0_out and float_1_out 0, issued_count_out 0, exception_out 0, op_ready_out 1.
REQ-034 Reset asserted mid-SEND or mid-WAIT SHALL abort the operation without completing any handshake; the FSM SHALL resume from IDLE on the first edge after deassertion.

Structure
REQ-035 Shared package fpu_pkg SHALL hold FP, float_sp, dispatch_state_e (2 bits) and the DEPTH default.
REQ-036 The FIFO SHALL be a sub-module fpu_pair_fifo (push/pop/full/empty/head), instantiated once.

Verification
REQ-037 Single pair: push A=0x3F800000, B=0x40000000 with both busy inputs low -> both reqs high for one cycle with the data; WAIT; ready_answer_in pulse -> issued_count_out=1, IDLE.
REQ-038 Skewed channels: float_1_busy_in held for 3 cycles -> channel 0 drops after 1 cycle, channel 1 req holds 4 cycles with stable data, pop happens only after channel 1 completes.
REQ-039 Full FIFO: push 5 pairs while fma_busy_in=1 -> op_ready_out=0 after the 4th push; 5th pair is held until a pop; the pairs then issue in order.
REQ-040 Exception: overflow_in=1 with ready_answer_in -> exception_out=1 and it stays high across later clean results.
REQ-041 Wrap and reset: 256 completions -> issued_count_out=0; rst asserted during SEND -> reqs drop immediately, FIFO empty, no count increment.
